// File: rtl/onchip_ram_pkg.sv
// Shared types and helpers for the pipelined on-chip RAM: FSM state encoding,
// legal read-latency range and the per-byte even-parity function.
package onchip_ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_t;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;

    // Even parity: stored bit makes the 9-bit group have an even number of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/onchip_ram_pipelined_if.sv
// Slave bus bundle of the pipelined on-chip RAM (request, flow control and
// read response). The master modport drives requests, the slave answers.
interface onchip_ram_pipelined_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    import onchip_ram_pkg::*;

    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic              clken;
    logic              reset_req;
    logic              freeze;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              readerror;
    logic              init_done;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
               clken, reset_req, freeze,
        input  waitrequest, readdata, readdatavalid, readerror, init_done
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
               clken, reset_req, freeze,
        output waitrequest, readdata, readdatavalid, readerror, init_done
    );

endinterface

// File: rtl/onchip_ram_array.sv
// Byte-lane RAM with one write port and one registered read port.
// With ONCHIP_RAM_PARITY_EN defined, a parity bit per byte is stored and checked.
module onchip_ram_array
    import onchip_ram_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BE_W-1:0]   wbe,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rerr
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Output register holds between reads so the top can present stale data.
    always_ff @(posedge clk) begin
        if (!reset_n)  rdata <= '0;
        else if (re)   rdata <= mem[raddr];
    end

`ifdef ONCHIP_RAM_PARITY_EN
    logic [BE_W-1:0] par_mem [DEPTH];
    logic [BE_W-1:0] rpar;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wbe[i]) par_mem[waddr][i] <= byte_parity(wdata[i*8 +: 8]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)  rpar <= '0;
        else if (re)   rpar <= par_mem[raddr];
    end

    always_comb begin
        rerr = 1'b0;
        for (int i = 0; i < BE_W; i++) begin
            if (byte_parity(rdata[i*8 +: 8]) != rpar[i]) rerr = 1'b1;
        end
    end
`else
    assign rerr = 1'b0;
`endif

endmodule

// File: rtl/onchip_ram_pipelined.sv
// Pipelined on-chip RAM slave: zero-fills after reset, then serves byte-masked
// writes and fixed-latency reads. Optional parity via ONCHIP_RAM_PARITY_EN.
//   state | meaning
//   INIT  | zero-fill one word per cycle, bus held off with waitrequest
//   IDLE  | normal operation, exits only through reset
module onchip_ram_pipelined
    import onchip_ram_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 64,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    onchip_ram_pipelined_if.slave  bus
);

    localparam int BE_W = DATA_W / 8;

    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
        $error("onchip_ram_pipelined: READ_LATENCY out of range");
    end

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_W-1:0]       fill_cnt;
    logic                    wr_accept;
    logic                    rd_accept;
    logic                    ram_we;
    logic [ADDR_W-1:0]       ram_waddr;
    logic [BE_W-1:0]         ram_wbe;
    logic [DATA_W-1:0]       ram_wdata;
    logic [DATA_W-1:0]       ram_rdata;
    logic                    ram_rerr;
    logic [READ_LATENCY-1:0] vld_pipe;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= INIT;
            fill_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) fill_cnt <= fill_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (fill_cnt == '1) state_next = IDLE;
            IDLE:    state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    assign bus.init_done   = (state == IDLE);
    assign bus.waitrequest = (state == INIT) | ~bus.clken | bus.reset_req | ~reset_n;

    // A combined read+write is a write only.
    assign wr_accept = bus.chipselect & bus.write & ~bus.waitrequest;
    assign rd_accept = bus.chipselect & bus.read & ~bus.write & ~bus.waitrequest;

    // Frozen writes are still accepted; they just never reach the array.
    assign ram_we    = (state == INIT) | (wr_accept & ~bus.freeze);
    assign ram_waddr = (state == INIT) ? fill_cnt : bus.address;
    assign ram_wbe   = (state == INIT) ? '1 : bus.byteenable;
    assign ram_wdata = (state == INIT) ? '0 : bus.writedata;

    onchip_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wbe     (ram_wbe),
        .wdata   (ram_wdata),
        .re      (rd_accept),
        .raddr   (bus.address),
        .rdata   (ram_rdata),
        .rerr    (ram_rerr)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) vld_pipe <= '0;
        else          vld_pipe <= (vld_pipe << 1) | READ_LATENCY'(rd_accept);
    end

    assign bus.readdatavalid = vld_pipe[READ_LATENCY-1];

    if (READ_LATENCY == 1) begin : g_lat1
        assign bus.readdata  = ram_rdata;
        assign bus.readerror = vld_pipe[0] & ram_rerr;
    end else begin : g_latn
        logic [READ_LATENCY-2:0][DATA_W-1:0] dat_q;
        logic [READ_LATENCY-2:0]             err_q;

        // Each stage loads only when its predecessor holds a live response,
        // so the last stage keeps the previous readdata between responses.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                dat_q <= '0;
                err_q <= '0;
            end else begin
                if (vld_pipe[0]) begin
                    dat_q[0] <= ram_rdata;
                    err_q[0] <= ram_rerr;
                end
                for (int k = 1; k < READ_LATENCY - 1; k++) begin
                    if (vld_pipe[k]) begin
                        dat_q[k] <= dat_q[k-1];
                        err_q[k] <= err_q[k-1];
                    end
                end
            end
        end

        assign bus.readdata  = dat_q[READ_LATENCY-2];
        assign bus.readerror = vld_pipe[READ_LATENCY-1] & err_q[READ_LATENCY-2];
    end

endmodule

// File: doc/onchip_ram_pipelined.md
ONCHIP_RAM_PIPELINED -- requirements
Module: onchip_ram_pipelined

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width; depth = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 64, meaning data width, a multiple of 8; BE_W = DATA_W/8.
REQ-003 SHALL have parameter READ_LATENCY, default 2, meaning accept-to-readdatavalid cycles, legal values 1..4.
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: synchronous active-low reset.
REQ-007 SHALL have port address, input, ADDR_W: word address.
REQ-008 SHALL have port chipselect, input, 1: slave select.
REQ-009 SHALL have port read, input, 1: read request.
REQ-010 SHALL have port write, input, 1: write request.
REQ-011 SHALL have port byteenable, input, BE_W: per-byte write enable.
REQ-012 SHALL have port writedata, input, DATA_W: write data.
REQ-013 SHALL have port clken, input, 1: acceptance enable.
REQ-014 SHALL have port reset_req, input, 1: pending-reset request; blocks acceptance.
REQ-015 SHALL have port freeze, input, 1: write-protect.
REQ-016 SHALL have port waitrequest, output, 1: request not accepted this cycle.
REQ-017 SHALL have port readdata, output, DATA_W: read data.
REQ-018 SHALL have port readdatavalid, output, 1: readdata valid this cycle.
REQ-019 SHALL have port readerror, output, 1: parity error qualifying readdatavalid.
REQ-020 SHALL have port init_done, output, 1: zero-fill complete.

Function
REQ-021 SHALL implement FSM states INIT and IDLE; INIT -> IDLE after the word at address DEPTH-1 is written; IDLE has no exit except reset.
REQ-022 In INIT, SHALL write all-zero to one word per cycle, counter 0..DEPTH-1; fill takes exactly DEPTH cycles; init_done = 1 only in IDLE.
REQ-023 SHALL drive waitrequest = (state==INIT) | ~clken | reset_req, combinationally.
REQ-024 Accept = chipselect & (read|write) & ~waitrequest; at most one accept per cycle; full throughput of one per cycle.
REQ-025 read and write both high on accept SHALL be treated as a write only; no read response is produced.
REQ-026 An accepted write SHALL update only the bytes with byteenable=1; all-zero byteenable leaves memory unchanged; freeze=1 SHALL discard the write while still accepting it.
REQ-027 An accepted read SHALL assert readdatavalid for exactly one cycle, exactly READ_LATENCY cycles later, in request order.
REQ-028 The response pipeline SHALL advance every cycle regardless of clken, reset_req or freeze; responses in flight are never dropped.
REQ-029 A read accepted in the cycle after a write to the same address SHALL return the new data; reads and writes accepted in the same cycle do not occur (REQ-025).
REQ-030 readdata SHALL hold its last value when readdatavalid=0.

Reset
REQ-031 With reset_n=0 at a clock edge: state=INIT, fill counter=0, pipeline cleared, readdatavalid=0, readerror=0, readdata=0, init_done=0; waitrequest=1 throughout.
REQ-032 Reset asserted during INIT or IDLE SHALL restart the fill from address 0; responses in flight are discarded.

Configuration
REQ-033 With ONCHIP_RAM_PARITY_EN defined: one even-parity bit SHALL be stored per byte on every write, including the zero fill, and checked on read; readerror=1 with readdatavalid if any enabled byte mismatches.
REQ-034 Without ONCHIP_RAM_PARITY_EN: no parity storage; readerror SHALL be constant 0.

Structure
REQ-035 Package onchip_ram_pkg SHALL hold the FSM state enum, the READ_LATENCY bounds constants and the byte-parity function.
REQ-036 Sub-module onchip_ram_array SHALL contain the byte-lane memory array: one write port, one registered read port, inferrable as block RAM.

Verification
REQ-037 Reset release -> waitrequest=1 for exactly 1024 cycles (defaults), then init_done=1; reads of addresses 0 and 1023 return 0.
REQ-038 Write 0x0123456789ABCDEF to address 5 with byteenable=0x0F, then read -> 0x0000000089ABCDEF after READ_LATENCY=2 cycles.
REQ-039 Eight back-to-back reads of addresses 0..7 -> eight consecutive readdatavalid pulses, in order; clken drop mid-burst stalls acceptance but not responses.
REQ-040 freeze=1 write of 0xFFFF... to address 3 -> accepted; read returns the prior value.
REQ-041 reset_n pulse at INIT counter 500 -> fill restarts; init_done rises 1024 cycles after release.
REQ-042 PARITY_EN: force a flipped bit in byte 2 of address 7 -> read gives readerror=1 with readdatavalid; other addresses readerror=0.
